// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // data_xor is the reduction XOR of the payload.
  function automatic logic parity_of(input parity_t mode, input logic data_xor);
    logic p;
    case (mode)
      PARITY_EVEN: p = data_xor;
      PARITY_ODD:  p = ~data_xor;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_piso.sv
// Parallel-in serial-out shift register: load wins over shift, LSB shifts out first.
module piso_shift_register #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_next
);

  logic [N-1:0] sr_d;
  logic [N-1:0] sr_q;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift_en) begin
      sr_d = {1'b0, sr_q[N-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // sout_next is the bit that becomes the LSB after the next shift.
  assign sout      = sr_q[0];
  assign sout_next = sr_q[1];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frames accepted words into start/data/parity/stop bits paced by baud_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter parity_t     PARITY    = PARITY_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned          BIT_CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [1:0]           LAST_STOP = 2'(STOP_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 frame_done_q, frame_done_d;
  logic                 accept;
  logic                 sr_shift;
  logic                 sr_lsb;
  logic                 sr_lsb_next;

  assign tx_ready   = (state_q == S_IDLE) & ~rst;
  assign busy       = (state_q != S_IDLE);
  assign accept     = tx_valid & tx_ready;
  assign tx         = tx_q;
  assign frame_done = frame_done_q;

  piso_shift_register #(
    .N(DATA_BITS)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (tx_data),
    .shift_en  (sr_shift),
    .sout      (sr_lsb),
    .sout_next (sr_lsb_next)
  );

  // tx is registered, so each branch computes the level for the bit that starts on this tick.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    parity_d     = parity_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    sr_shift     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (accept) begin
          state_d  = S_SYNC;
          parity_d = parity_of(PARITY, ^tx_data);
        end
      end
      S_SYNC: begin
        if (baud_tick) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          tx_d      = sr_lsb;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d    = S_STOP;
              stop_cnt_d = '0;
              tx_d       = UART_IDLE_LEVEL;
            end
          end else begin
            tx_d = sr_lsb_next;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          state_d    = S_STOP;
          stop_cnt_d = '0;
          tx_d       = UART_IDLE_LEVEL;
        end
      end
      S_STOP: begin
        tx_d = UART_IDLE_LEVEL;
        if (baud_tick) begin
          stop_cnt_d = stop_cnt_q + 2'd1;
          if (stop_cnt_q == LAST_STOP) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = UART_IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      parity_q     <= 1'b0;
      tx_q         <= UART_IDLE_LEVEL;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no/even/odd parity and two stop bits.
module tb_uart_tx;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       valid_r [4];
  logic [7:0] data_r  [4];
  logic       tx_w    [4];
  logic       ready_w [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_NONE)) dut_none (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_r[0]), .tx_valid(valid_r[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_EVEN)) dut_even (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_r[1]), .tx_valid(valid_r[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_ODD)) dut_odd (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_r[2]), .tx_valid(valid_r[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(PARITY_NONE)) dut_stop2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_r[3]), .tx_valid(valid_r[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle tick every 4 clocks, updated on the falling edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt  = (tick_cnt + 1) % 4;
      baud_tick = (tick_cnt == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick_edge();
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 16) begin
      @(posedge clk);
      n++;
      seen = baud_tick;
    end
    #1;
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    int n = 0;
    data_r[idx]  = d;
    valid_r[idx] = 1'b1;
    while (ready_w[idx] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", ready_w[idx], 1);
    @(posedge clk); #1;
    valid_r[idx] = 1'b0;
    chk("accept_busy", busy_w[idx], 1);
    chk("accept_ready", ready_w[idx], 0);
  endtask

  // Samples tx after each of the next nbits tick edges (first sent bit lands in the MSB
  // of the nbits-wide result), then checks the ending tick edge and the following cycle.
  task automatic capture_frame(input int idx, input int nbits, output logic [15:0] cap);
    int   edges     = 0;
    int   guard     = 0;
    logic bad_done  = 1'b0;
    logic bad_ready = 1'b0;
    cap = '0;
    while (edges <= nbits && guard < 400) begin
      @(posedge clk);
      guard++;
      if (baud_tick) begin
        edges++;
        #1;
        if (edges <= nbits) begin
          cap = {cap[14:0], tx_w[idx]};
          if (done_w[idx] !== 1'b0) bad_done = 1'b1;
          if (ready_w[idx] !== 1'b0) bad_ready = 1'b1;
        end
      end
    end
    chk("frame_in_time", (guard < 400), 1);
    chk("done_early", bad_done, 0);
    chk("ready_early", bad_ready, 0);
    chk("done_pulse", done_w[idx], 1);
    chk("ready_after_stop", ready_w[idx], 1);
    chk("tx_idle_after", tx_w[idx], 1);
    @(posedge clk); #1;
    chk("done_single", done_w[idx], 0);
  endtask

  initial begin
    logic [15:0] cap;
    int          n;
    int          bad;
    int          ticks;

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_r[i] = 1'b0;
      data_r[i]  = 8'h00;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx_w[0], 1);
    chk("rst_ready", ready_w[0], 0);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_done", done_w[0], 0);
    rst = 1'b0;
    #1;
    chk("rel_ready", ready_w[0], 1);

    // Basic frame, no parity
    send(0, 8'hA5);
    capture_frame(0, 10, cap);
    chk("frame_a5_none", cap, 10'b0_10100101_1);

    // Parity variants
    send(1, 8'hA5);
    capture_frame(1, 11, cap);
    chk("frame_a5_even", cap, 11'b0_10100101_0_1);
    send(1, 8'h07);
    capture_frame(1, 11, cap);
    chk("frame_07_even", cap, 11'b0_11100000_1_1);
    send(2, 8'h07);
    capture_frame(2, 11, cap);
    chk("frame_07_odd", cap, 11'b0_11100000_0_1);

    // Two stop bits
    send(3, 8'h00);
    capture_frame(3, 11, cap);
    chk("frame_00_stop2", cap, 11'b0_00000000_11);

    // Held valid: two frames back to back, data changed after each acceptance
    @(posedge clk); #1;
    data_r[0]  = 8'h3C;
    valid_r[0] = 1'b1;
    @(posedge clk); #1;
    chk("hs_accept1", busy_w[0], 1);
    data_r[0] = 8'hC3;
    capture_frame(0, 10, cap);
    chk("hs_frame1", cap, 10'b0_00111100_1);
    chk("hs_accept2", busy_w[0], 1);
    valid_r[0] = 1'b0;
    data_r[0]  = 8'h00;
    capture_frame(0, 10, cap);
    chk("hs_frame2", cap, 10'b0_11000011_1);
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) bad++;
    end
    chk("hs_no_third", bad, 0);

    // Idle ticks
    bad   = 0;
    ticks = 0;
    n     = 0;
    while (ticks < 20 && n < 200) begin
      @(posedge clk);
      if (baud_tick) ticks++;
      n++;
      #1;
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
    end
    chk("idle_ticks_quiet", bad, 0);

    // Acceptance on a tick edge: frame starts one full period later
    wait_tick_edge();
    repeat (3) @(posedge clk);
    #1;
    data_r[0]  = 8'h81;
    valid_r[0] = 1'b1;
    @(posedge clk); #1;
    valid_r[0] = 1'b0;
    chk("coinc_busy", busy_w[0], 1);
    chk("coinc_tx_idle", tx_w[0], 1);
    n = 0;
    while (tx_w[0] === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("coinc_start_delay", n, 4);
    capture_frame(0, 9, cap);
    chk("coinc_frame_81", cap, 9'b10000001_1);

    // Reset during data bit 3 of 0xFF
    send(0, 8'hFF);
    repeat (5) wait_tick_edge();
    @(posedge clk); #1;
    chk("pre_rst_busy", busy_w[0], 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx_w[0], 1);
    chk("mid_rst_busy", busy_w[0], 0);
    chk("mid_rst_ready", ready_w[0], 0);
    chk("mid_rst_done", done_w[0], 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", ready_w[0], 1);
    chk("post_rst_tx", tx_w[0], 1);
    send(0, 8'h55);
    capture_frame(0, 10, cap);
    chk("frame_55_after_rst", cap, 10'b0_10101010_1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
